// File: rtl/miller_pkg.sv
// miller_pkg: shared defaults, state and sequence types for the Modified Miller link (MILLER_PARITY_EN adds the PAR state)
package miller_pkg;

    localparam int CLK_PER_ETU_DEF = 32;
    localparam int PAUSE_LEN_DEF   = 8;

`ifdef MILLER_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_DATA, ST_EOF0, ST_EOFY, ST_PAR} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_DATA, ST_EOF0, ST_EOFY} state_t;
`endif

    typedef enum logic [1:0] {SEQ_Y, SEQ_X, SEQ_Z} seq_t;

    // A 1 is always X; a 0 is Y right after an X and Z after anything else
    function automatic seq_t encode_bit(input logic b, input seq_t prev);
        return b ? SEQ_X : (prev == SEQ_X ? SEQ_Y : SEQ_Z);
    endfunction

endpackage

// File: rtl/miller_etu_timer.sv
// miller_etu_timer: free-running ETU counter with synchronous clear and terminal-count pulse
module miller_etu_timer
    import miller_pkg::*;
#(
    parameter int CLK_PER_ETU = CLK_PER_ETU_DEF
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clr_i,
    output logic [$clog2(CLK_PER_ETU)-1:0] cnt_o,
    output logic                           tc_o
);

    localparam int W = $clog2(CLK_PER_ETU);

    logic [W-1:0] cnt_q, cnt_d;

    // Terminal pulse on the last clock of the ETU, then wrap to 0
    always_comb begin
        tc_o  = !clr_i && cnt_q == W'(CLK_PER_ETU - 1);
        cnt_d = (clr_i || tc_o) ? '0 : cnt_q + 1'b1;
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        cnt_q <= rst_i ? '0 : cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/miller_pause_encoder.sv
// miller_pause_encoder: framed Modified Miller pause encoder (SoF Z, data, EoF 0+Y); MILLER_PARITY_EN inserts odd parity per byte
module miller_pause_encoder
    import miller_pkg::*;
#(
    parameter int CLK_PER_ETU = CLK_PER_ETU_DEF,
    parameter int PAUSE_LEN   = PAUSE_LEN_DEF
) (
    input  logic in_clk,
    input  logic in_PoR,
    input  logic in_start,
    input  logic in_bit,
    input  logic in_bit_valid,
    input  logic in_bit_last,
    output logic out_bit_ready,
    output logic out_pause,
    output logic out_busy,
    output logic out_done,
    output logic out_err
);

    localparam int W    = $clog2(CLK_PER_ETU);
    localparam int HALF = CLK_PER_ETU / 2;

    state_t       state_q, state_d;
    seq_t         seq_q, seq_d;
    logic         last_q, last_d;
    logic         pause_q, pause_d;
    logic         done_q, done_d;
    logic         idle, fetch, tc;
    logic [W-1:0] cnt, cnt_nxt;
`ifdef MILLER_PARITY_EN
    logic [2:0]   nbit_q, nbit_d;
    logic         acc_q, acc_d;
    logic         par_due;
`endif

    function automatic logic pause_at(input seq_t s, input logic [W-1:0] c);
        return s == SEQ_Z ? int'(c) < PAUSE_LEN
             : s == SEQ_X ? (int'(c) >= HALF && int'(c) < HALF + PAUSE_LEN)
             : 1'b0;
    endfunction

    miller_etu_timer #(.CLK_PER_ETU(CLK_PER_ETU)) u_timer (
        .clk_i (in_clk),
        .rst_i (in_PoR),
        .clr_i (idle),
        .cnt_o (cnt),
        .tc_o  (tc)
    );

    // Fetch strobe on the last clock of SOF and of every ETU that is followed by another data bit
    always_comb begin
        idle = state_q == ST_IDLE;
`ifdef MILLER_PARITY_EN
        par_due = state_q == ST_DATA && nbit_q == 3'd0;
        fetch   = tc && !last_q && (state_q == ST_SOF || (state_q == ST_DATA && !par_due) || state_q == ST_PAR);
`else
        fetch   = tc && (state_q == ST_SOF || (state_q == ST_DATA && !last_q));
`endif
        cnt_nxt = (idle || tc) ? '0 : cnt + 1'b1;
    end

    // Next frame state, next symbol and the pause level for the coming clock
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        last_d  = last_q;
        done_d  = 1'b0;
`ifdef MILLER_PARITY_EN
        nbit_d  = nbit_q;
        acc_d   = acc_q;
`endif
        if (idle) begin
            if (in_start) begin
                state_d = ST_SOF;
                seq_d   = SEQ_Z;
                last_d  = 1'b0;
`ifdef MILLER_PARITY_EN
                nbit_d  = 3'd0;
                acc_d   = 1'b0;
`endif
            end
        end else if (fetch) begin
            state_d = in_bit_valid ? ST_DATA : ST_EOF0;
            seq_d   = encode_bit(in_bit_valid && in_bit, seq_q);
            last_d  = in_bit_valid && in_bit_last;
`ifdef MILLER_PARITY_EN
            nbit_d  = nbit_q + {2'b00, in_bit_valid};
            acc_d   = acc_q ^ (in_bit_valid && in_bit);
`endif
        end else if (tc) begin
`ifdef MILLER_PARITY_EN
            if (par_due) begin
                state_d = ST_PAR;
                seq_d   = encode_bit(~acc_q, seq_q);
                acc_d   = 1'b0;
            end else
`endif
            if (state_q == ST_EOF0) begin
                state_d = ST_EOFY;
                seq_d   = SEQ_Y;
            end else if (state_q == ST_EOFY) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_EOF0;
                seq_d   = encode_bit(1'b0, seq_q);
            end
        end
        pause_d = state_d != ST_IDLE && pause_at(seq_d, cnt_nxt);
    end

    // Frame state and registered outputs
    always_ff @(posedge in_clk) begin
        if (in_PoR) begin
            state_q <= ST_IDLE;
            seq_q   <= SEQ_Y;
            last_q  <= 1'b0;
            pause_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef MILLER_PARITY_EN
            nbit_q  <= 3'd0;
            acc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            last_q  <= last_d;
            pause_q <= pause_d;
            done_q  <= done_d;
`ifdef MILLER_PARITY_EN
            nbit_q  <= nbit_d;
            acc_q   <= acc_d;
`endif
        end
    end

    assign out_pause     = pause_q;
    assign out_busy      = !idle;
    assign out_done      = done_q;
    assign out_bit_ready = fetch;
    assign out_err       = fetch && !in_bit_valid;

endmodule

// File: tb/tb_miller_pause_encoder.sv
// tb_miller_pause_encoder: randomized scoreboard bench for miller_pause_encoder (honours MILLER_PARITY_EN)
`timescale 1ns/1ps
module tb_miller_pause_encoder;

    localparam int ETU = 32;
    localparam int PL  = 8;
`ifdef MILLER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam logic [ETU-1:0] ZP = ETU'((1 << PL) - 1);
    localparam logic [ETU-1:0] XP = ZP << (ETU / 2);

    typedef struct {
        int etus;
        int rdy;
        int err;
    } frame_t;

    logic clk = 1'b0;
    logic in_PoR = 1'b1, in_start = 1'b1, in_bit = 1'b0, in_bit_valid = 1'b0, in_bit_last = 1'b0;
    logic out_bit_ready, out_pause, out_busy, out_done, out_err;

    int errors = 0;
    int checks = 0;
    logic [ETU-1:0] pq[$];
    frame_t fq[$];
    int bits[64];

    miller_pause_encoder #(.CLK_PER_ETU(ETU), .PAUSE_LEN(PL)) dut (
        .in_clk        (clk),
        .in_PoR        (in_PoR),
        .in_start      (in_start),
        .in_bit        (in_bit),
        .in_bit_valid  (in_bit_valid),
        .in_bit_last   (in_bit_last),
        .out_bit_ready (out_bit_ready),
        .out_pause     (out_pause),
        .out_busy      (out_busy),
        .out_done      (out_done),
        .out_err       (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [ETU-1:0] got, input logic [ETU-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Miller rule in terms of logical values: 1 -> pause mid-ETU, 0 -> no pause after a 1, else pause at start
    function automatic logic [ETU-1:0] enc(input int b, input bit prev_one);
        return b != 0 ? XP : (prev_one ? '0 : ZP);
    endfunction

    // Expected ETU patterns and frame totals for a source that delivers k of n bits
    task automatic push_model(input int n, input int k);
        frame_t f;
        bit prev_one;
        int ones;
        prev_one = 1'b0;
        pq.push_back(ZP);
        f.etus = 1;
        for (int i = 0; i < k; i++) begin
            pq.push_back(enc(bits[i], prev_one));
            prev_one = bits[i] != 0;
            f.etus++;
            if (PAR_EN && i % 8 == 7) begin
                ones = 0;
                for (int j = i - 7; j <= i; j++) ones += bits[j];
                pq.push_back(enc(ones % 2 == 0 ? 1 : 0, prev_one));
                prev_one = ones % 2 == 0;
                f.etus++;
            end
        end
        pq.push_back(enc(0, prev_one));
        pq.push_back('0);
        f.etus += 2;
        f.rdy = k + (k < n ? 1 : 0);
        f.err = k < n ? 1 : 0;
        fq.push_back(f);
    endtask

    task automatic run_frame(input int n, input int k);
        int idx, cyc;
        bit xf;
        push_model(n, k);
        in_start = 1'b1;
        @(posedge clk); #1;
        in_start = 1'b0;
        idx = 0;
        cyc = 0;
        while (out_busy && cyc < 5000) begin
            if (out_bit_ready) begin
                in_bit_valid = idx < k;
                in_bit       = bits[idx] != 0;
                in_bit_last  = idx == n - 1;
            end else begin
                in_bit_valid = 1'($urandom);
                in_bit       = 1'($urandom);
                in_bit_last  = 1'($urandom);
                in_start     = 1'($urandom);
            end
            @(negedge clk);
            xf = out_bit_ready && in_bit_valid;
            @(posedge clk); #1;
            if (xf) idx++;
            cyc++;
        end
        in_start = 1'b0;
        in_bit_valid = 1'b0;
        if (cyc >= 5000) check("frame_timeout", 1, 0);
        check("bits_taken", idx, k);
        repeat ($urandom_range(2, 6)) @(posedge clk);
        #1;
    endtask

    // Monitor: collect one pause pattern per busy ETU and frame totals, compare against the queues
    initial begin
        int ecyc, busy_n, rdy_n, err_n;
        bit prev_busy;
        logic [ETU-1:0] acc;
        frame_t f;
        ecyc = 0; busy_n = 0; rdy_n = 0; err_n = 0; prev_busy = 0; acc = '0;
        forever begin
            @(negedge clk);
            if (in_PoR) begin
                pq.delete();
                fq.delete();
                ecyc = 0; busy_n = 0; rdy_n = 0; err_n = 0; prev_busy = 0;
            end else begin
                if (out_busy) begin
                    acc[ecyc] = out_pause;
                    ecyc++;
                    busy_n++;
                    if (ecyc == ETU) begin
                        ecyc = 0;
                        if (pq.size() == 0) check("etu_extra", 1, 0);
                        else check("etu_pattern", acc, pq.pop_front());
                    end
                end else begin
                    check("idle_pause", out_pause, 0);
                end
                if (out_bit_ready) rdy_n++;
                if (out_err) err_n++;
                if (out_done) begin
                    check("done_after_busy", prev_busy, 1);
                    if (fq.size() == 0) check("done_unexpected", 1, 0);
                    else begin
                        f = fq.pop_front();
                        check("busy_cycles", busy_n, f.etus * ETU);
                        check("ready_pulses", rdy_n, f.rdy);
                        check("err_pulses", err_n, f.err);
                    end
                    busy_n = 0; rdy_n = 0; err_n = 0; ecyc = 0;
                end
                prev_busy = out_busy;
            end
        end
    end

    initial begin
        int n, k;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_pause", out_pause, 0);
            check("rst_busy", out_busy, 0);
            check("rst_ready", out_bit_ready, 0);
            check("rst_done", out_done, 0);
        end
        in_PoR = 1'b0;
        in_start = 1'b0;
        @(posedge clk); #1;
        check("rst_nostart", out_busy, 0);

        bits[0] = 1;
        run_frame(1, 1);
        bits[0] = 0; bits[1] = 0; bits[2] = 1; bits[3] = 0;
        run_frame(4, 4);
        bits[0] = 1; bits[1] = 0; bits[2] = 1;
        run_frame(3, 2);
        bits[0] = 1;
        for (int i = 1; i < 8; i++) bits[i] = 0;
        run_frame(8, 8);

        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(1, 20);
            k = $urandom_range(0, 3) == 0 ? $urandom_range(0, n - 1) : n;
            for (int i = 0; i < n; i++) bits[i] = $urandom_range(0, 1);
            run_frame(n, k);
        end

        bits[0] = 1;
        push_model(1, 1);
        in_start = 1'b1;
        @(posedge clk); #1;
        in_start = 1'b0;
        in_bit_valid = 1'b1; in_bit = 1'b1; in_bit_last = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("x_pause_c18", out_pause, 1);
        in_PoR = 1'b1;
        @(posedge clk); #1;
        check("midrst_pause", out_pause, 0);
        check("midrst_busy", out_busy, 0);
        in_PoR = 1'b0;
        in_bit_valid = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check("frames_pending", fq.size(), 0);
        check("etus_pending", pq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/miller_pause_encoder.md
# miller_pause_encoder

Transmit-side Modified Miller encoder for the 106 kbit/s reader-to-card link, the counterpart of the SoF detector and Miller decoder chain. Accepts a serial bit stream over a valid/ready handshake, frames it with SoF (sequence Z) and EoF (logic 0 followed by sequence Y), and drives a pause envelope (`out_pause`) to the carrier modulator. All ETU timing is derived from `in_clk` (3.39 MHz, 32 clocks per ETU).

## Interface
- `CLK_PER_ETU`, 32: clocks per ETU; must be even and at least 8.
- `PAUSE_LEN`, 8: pause width in clocks; must be less than CLK_PER_ETU/2.
- `in_clk`  input  1  system clock, rising edge.
- `in_PoR`  input  1  reset, synchronous, active-high.
- `in_start`  input  1  frame request; sampled only in IDLE.
- `in_bit`  input  1  next data bit, transmitted in the order presented.
- `in_bit_valid`  input  1  `in_bit` and `in_bit_last` are valid.
- `in_bit_last`  input  1  the current bit is the last bit of the frame.
- `out_bit_ready`  output  1  encoder accepts a bit this cycle.
- `out_pause`  output  1  1 = carrier off (pause active).
- `out_busy`  output  1  frame in progress.
- `out_done`  output  1  one-cycle pulse at frame end.
- `out_err`  output  1  one-cycle pulse on source underflow.

## Operation
- Sequences, by ETU count c:
  - X: pause for c = CLK_PER_ETU/2 to CLK_PER_ETU/2+PAUSE_LEN-1.
  - Z: pause for c = 0 to PAUSE_LEN-1.
  - Y: no pause.
- Bit mapping:
  - 1 maps to X.
  - 0 maps to Y, or to Z if the previous symbol was 0, Z, or SoF.
- States:
  - IDLE: on `in_start`, go to SOF.
  - SOF: one ETU of Z, then DATA.
  - DATA: one ETU per accepted bit. After the last bit go to EOF0.
  - EOF0: one ETU encoding logic 0 with the normal rule, so Z after 0, otherwise Y. Then go to EOFY.
  - EOFY: one ETU of Y, then IDLE.
- Handshake:
  - `out_bit_ready` = 1 only at c = CLK_PER_ETU-1 of SOF and of each non-last DATA ETU.
  - A transfer occurs when `in_bit_valid` and `out_bit_ready` are both 1.
  - The accepted bit is encoded in the next ETU.
- Underflow: if `in_bit_valid` = 0 at the fetch cycle:
  - `out_err` pulses for one cycle.
  - The state goes to EOF0, with the previous symbol used for the 0-rule.
- `in_start` is ignored while `out_busy` = 1.
- `out_done` pulses in the first IDLE cycle after EOFY.

## Timing
- Reset: on the first edge with `in_PoR` = 1, all outputs are 0, the state is IDLE, and the counter is 0. Reset mid-pause drops `out_pause` at that same edge.
- Start latency: if `in_start` is sampled at edge t, the SOF ETU occupies cycles t+1 to t+CLK_PER_ETU, and `out_pause` = 1 in cycles t+1 to t+PAUSE_LEN.
- `out_pause` is registered, with no combinational path from the inputs.
- Counter:
  - Width is $clog2(CLK_PER_ETU).
  - Wraps from CLK_PER_ETU-1 to 0 with a terminal pulse.
  - Held at 0 in IDLE.
- Frame length for N bits is N+3 ETUs. `out_busy` is 1 from t+1 through the last cycle of EOFY.

## Configuration
- `MILLER_PARITY_EN` defined:
  - After every 8th accepted data bit, the encoder inserts one ETU carrying the odd-parity bit of those 8 bits, encoded with the normal rules.
  - `out_bit_ready` stays 0 at the fetch cycle that precedes the parity ETU.
  - If the 8th bit is the last bit, parity is sent and then EOF0.
  - Frames that do not end on a byte boundary get no trailing parity.
- `MILLER_PARITY_EN` undefined: no insertion, and no parity logic is synthesised.

## Structure
- Shared package `miller_pkg`:
  - Default CLK_PER_ETU and PAUSE_LEN.
  - State enumeration (IDLE, SOF, DATA, EOF0, EOFY, and PAR under the macro).
  - Sequence enumeration (SEQ_X, SEQ_Y, SEQ_Z).
- Sub-module `miller_etu_timer`: ETU counter with synchronous clear, a count output, and a terminal-count pulse. It is reusable by the decoder side.

## Test plan
- Reset: hold `in_PoR` = 1 for 3 cycles with `in_start` = 1. Required: `out_pause`, `out_busy`, `out_bit_ready`, `out_done` all 0, and no frame starts.
- Single bit 1 (`in_bit_last` = 1), start sampled at t:
  - Pause in t+1 to t+8 (SoF Z).
  - Pause in t+49 to t+56 (X).
  - No pause from t+65 to t+128 (EOF0 Y and EOFY Y).
  - `out_done` at t+129.
- Bits 0,0,1,0: symbols SoF-Z, Z, Z, X, Y, then EOF0 Z and EOFY Y. Exactly four `out_bit_ready` pulses.
- Underflow: drop `in_bit_valid` after 2 bits (1,0). Required: `out_err` one pulse at the fetch cycle; then EOF0 Z, EOFY Y, `out_done`.
- Reset at c = 18 of an X ETU: `out_pause` = 0 and `out_busy` = 0 at that edge, and no `out_done`.
- `MILLER_PARITY_EN`: byte 0x01, LSB first, last bit flagged.
  - Ninth ETU carries parity 0 encoded as Z, since bit 7 = 0.
  - No `out_bit_ready` before the parity ETU.
  - EOF0 Z and EOFY Y follow.
  - Without the macro: EOF0 follows bit 8 directly.
